obi_mem_device: RTL and testbench
=================================

// Module: obi_mem_device
// PURPOSE
//  OBI responder (device) end of the core's memory bus: accepts requests from an OBI host
//  interface, grants them after a configurable number of wait states, and returns read data
//  through a fixed-latency pipeline. Backed by an internal word-addressed 64-bit RAM.
//  Used as the instruction/data memory model in simulation and as on-chip scratch RAM.
// PARAMETERS
//  MEM_WORDS     1024  number of 64-bit words; power of two; IDX_W = $clog2(MEM_WORDS)
//  WAIT_CYCLES   0     cycles gnt_o is held low per request before granting (0..15)
//  READ_LATENCY  1     cycles from accept edge to rvalid_o (1..4)
//  INIT_FILE     ""    $readmemh image loaded at time 0 when non-empty
// PORTS
//  clk_i     in   1   clock, all logic on rising edge
//  rst_i     in   1   synchronous reset, active-high
//  req_i     in   1   OBI request valid
//  we_i      in   1   1 = write, 0 = read
//  be_i      in   8   byte enables, bit n = byte lane n (bits 8n+7:8n)
//  addr_i    in   64  byte address; word index = addr_i[IDX_W+2:3]
//  wdata_i   in   64  write data
//  gnt_o     out  1   grant; transfer occurs on a cycle with req_i && gnt_o
//  rvalid_o  out  1   read response valid, one cycle per accepted read
//  rdata_o   out  64  read data, valid when rvalid_o
// BEHAVIOUR
//  Reset: gnt_o=0 (forced while rst_i high), rvalid_o=0, rdata_o=0, FSM=IDLE, wait counter=0,
//   response pipeline valid bits cleared. RAM contents are not reset.
//  Addressing: addr_i[2:0] ignored; bits above IDX_W+2 ignored (memory aliases every
//   MEM_WORDS*8 bytes). No error response exists.
//  Grant FSM (IDLE, WAIT), 4-bit counter cnt:
//   - WAIT_CYCLES==0: FSM stays IDLE; gnt_o = req_i (combinational); back-to-back transfers
//     every cycle.
//   - IDLE: gnt_o=0; if req_i -> WAIT, cnt<=WAIT_CYCLES-1.
//   - WAIT: gnt_o = req_i && cnt==0; if cnt!=0 cnt<=cnt-1; on grant -> IDLE.
//     req_i dropped in WAIT (host violation) -> IDLE, nothing transferred.
//   - Net effect: a held request sees exactly WAIT_CYCLES low-gnt cycles, grant in cycle
//     WAIT_CYCLES after req_i rises; each subsequent request pays the full wait again.
//   - Request inputs are sampled only in the grant cycle.
//  Writes: on accept edge, RAM byte lane n updated iff be_i[n]; be_i==0 is granted, no update.
//   Writes produce NO rvalid_o (host tracks read responses only).
//  Reads: RAM word read at the accept edge (sees every write accepted in earlier cycles); be_i
//   ignored, full word returned. Data + valid enter a READ_LATENCY-deep shift pipeline;
//   rvalid_o high exactly READ_LATENCY cycles after the accept cycle, for one cycle.
//   Fully pipelined: back-to-back accepted reads give back-to-back rvalid_o, strictly in order.
//   No rready: responder never stalls responses; up to READ_LATENCY reads in flight.
//  rdata_o holds last returned value while rvalid_o low.
//  Read and write to same word in consecutive cycles: read accepted first returns old data;
//   read accepted after the write returns new data.
//  Reset mid-operation: in-flight reads discarded (no rvalid_o after rst_i falls); FSM to IDLE,
//   wait count restarts; a write accepted before reset remains in RAM.
// TESTING
//  1 W=0,L=1: write 0x1122334455667788 @0x10 be=FF, read @0x10 next cycle -> gnt same cycle
//    each, rvalid_o one cycle after read accept, rdata_o=0x1122334455667788; no rvalid on write.
//  2 Then write 0xAAAAAAAAAAAAAAAA @0x10 be=0x0F, read @0x10 -> rdata_o=0x11223344AAAAAAAA;
//    write be=0x00 then read -> unchanged.
//  3 W=2: req_i held from cycle 0 -> gnt_o low cycles 0,1, high cycle 2; new req cycle 3 ->
//    grant cycle 5; req_i dropped cycle 4 instead -> no grant, FSM IDLE, RAM unchanged.
//  4 L=3: reads @0x0,0x8,0x10 accepted cycles 0,1,2 -> rvalid_o cycles 3,4,5, data in order.
//  5 L=3: read accepted cycle 0, rst_i high cycle 1 -> gnt_o=0 during reset, no rvalid_o ever.
//  6 MEM_WORDS=1024: write 0xDEADBEEF00000001 @0x2000 -> read @0x0 returns it (aliasing).

Source files
------------

// File: rtl/obi_mem_device.sv
// obi_mem_device: OBI responder fronting a word-addressed 64-bit byte-writable RAM.
// Latency: grant after WAIT_CYCLES wait states; read data READ_LATENCY cycles after accept.
// Backpressure: gnt_o held low during wait states; responses are never stalled (no rready).
module obi_mem_device #(
    parameter int    MEM_WORDS    = 1024,
    parameter int    WAIT_CYCLES  = 0,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [7:0]  be_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [63:0] rdata_o
);
    localparam int         IDX_W    = $clog2(MEM_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [63:0]      mem [MEM_WORDS];
    logic [IDX_W-1:0] idx;
    logic             xfer, rd_acc, wr_acc;

    logic [READ_LATENCY-1:0] pipe_vld;
    logic [63:0]             pipe_dat [READ_LATENCY];

    // Address bits outside the word index are don't-care (memory aliases).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[63:IDX_W+3], addr_i[2:0]};

    assign idx    = addr_i[IDX_W+2:3];
    assign xfer   = req_i && gnt_o;
    assign rd_acc = xfer && !we_i;
    assign wr_acc = xfer && we_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_o   = 1'b0;
        if (WAIT_CYCLES == 0) begin
            gnt_o = req_i;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
                S_WAIT: begin
                    gnt_o = req_i && (cnt_q == 4'd0);
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end
                    // A dropped request abandons the wait; the next one starts over.
                    if (!req_i || gnt_o) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (rst_i) begin
            gnt_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            for (int b = 0; b < 8; b++) begin
                if (be_i[b]) begin
                    mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Data registers only advance behind a valid entry, so the last stage
    // keeps the most recent response visible between rvalid pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_dat[i] <= 64'd0;
            end
        end else begin
            pipe_vld[0] <= rd_acc;
            if (rd_acc) begin
                pipe_dat[0] <= mem[idx];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_dat[i] <= pipe_dat[i-1];
                end
            end
        end
    end

    assign rvalid_o = pipe_vld[READ_LATENCY-1];
    assign rdata_o  = pipe_dat[READ_LATENCY-1];
endmodule

// File: tb/tb_obi_mem_device.sv
// Bench for obi_mem_device: three configurations driven by directed and random OBI
// traffic, checked against a transaction-level model of grants, memory and responses.
module tb_obi_mem_device;
    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req    [ND];
    logic        we     [ND];
    logic [7:0]  be     [ND];
    logic [63:0] addr   [ND];
    logic [63:0] wdata  [ND];
    logic        gnt    [ND];
    logic        rvalid [ND];
    logic [63:0] rdata  [ND];

    int wc  [ND] = '{0, 2, 0};
    int lat [ND] = '{1, 4, 3};

    obi_mem_device #(.MEM_WORDS(1024), .WAIT_CYCLES(0), .READ_LATENCY(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]));
    obi_mem_device #(.MEM_WORDS(1024), .WAIT_CYCLES(2), .READ_LATENCY(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]));
    obi_mem_device #(.MEM_WORDS(1024), .WAIT_CYCLES(0), .READ_LATENCY(3)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .req_i(req[2]), .we_i(we[2]), .be_i(be[2]),
        .addr_i(addr[2]), .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
        .rdata_o(rdata[2]));

    // Reference model state
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          held [ND];
    logic        acc  [ND];
    logic [63:0] mref [ND][1024];
    logic [63:0] last [ND];
    int          due  [ND][8];
    logic [63:0] qd   [ND][8];
    int          qh   [ND];
    int          qt   [ND];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: inputs are already applied; check outputs, advance the model.
    task automatic step();
        #1;
        for (int d = 0; d < ND; d++) begin
            logic eg;
            int   idx;
            eg = req[d] && !rst && (held[d] == wc[d]);
            chk($sformatf("gnt%0d", d), 64'(gnt[d]), 64'(eg));
            while (qh[d] != qt[d] && due[d][qh[d] % 8] < cyc) qh[d]++;
            if (qh[d] != qt[d] && due[d][qh[d] % 8] == cyc) begin
                chk($sformatf("rvalid%0d", d), 64'(rvalid[d]), 64'd1);
                last[d] = qd[d][qh[d] % 8];
                qh[d]++;
            end else begin
                chk($sformatf("rvalid%0d", d), 64'(rvalid[d]), 64'd0);
            end
            chk($sformatf("rdata%0d", d), rdata[d], last[d]);
            idx    = int'(addr[d][12:3]);
            acc[d] = eg;
            if (eg && !we[d]) begin
                due[d][qt[d] % 8] = cyc + lat[d];
                qd[d][qt[d] % 8]  = mref[d][idx];
                qt[d]++;
            end
            if (eg && we[d]) begin
                for (int b = 0; b < 8; b++)
                    if (be[d][b]) mref[d][idx][8*b +: 8] = wdata[d][8*b +: 8];
            end
            held[d] = (req[d] && !eg && !rst) ? held[d] + 1 : 0;
            if (rst) begin
                qh[d]   = qt[d];
                last[d] = 64'd0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic xfer(input int d, input logic w, input logic [7:0] b,
                        input logic [63:0] a, input logic [63:0] wd, output int n);
        req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc[d] && n < 40);
        if (!acc[d]) chk($sformatf("xfer_timeout%0d", d), 64'd0, 64'd1);
        req[d] = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        int          n;
        int          cnt;
        int          first;
        logic [63:0] got [3];
        logic [63:0] saved;

        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; be[d] = 8'h00; addr[d] = '0; wdata[d] = '0;
            held[d] = 0; acc[d] = 1'b0; last[d] = 64'd0; qh[d] = 0; qt[d] = 0;
        end
        @(negedge clk);
        req[1] = 1'b1;                      // request during reset must not be granted
        idle(2);
        req[1] = 1'b0;
        rst = 1'b0;
        idle(1);

        // Give every word used below a known value.
        for (int w = 0; w < 16; w++)
            for (int d = 0; d < ND; d++)
                xfer(d, 1'b1, 8'hFF, 64'(w * 8), {$urandom, $urandom}, n);

        // Full write, then read back on the next cycle.
        xfer(0, 1'b1, 8'hFF, 64'h10, 64'h1122334455667788, n);
        chk("t1_wr_cycles", 64'(n), 64'd1);
        xfer(0, 1'b0, 8'h00, 64'h10, 64'd0, n);
        chk("t1_rd_cycles", 64'(n), 64'd1);
        idle(2);
        chk("t1_rdata", rdata[0], 64'h1122334455667788);

        // Partial byte enables, then an all-zero byte enable.
        xfer(0, 1'b1, 8'h0F, 64'h10, 64'hAAAAAAAAAAAAAAAA, n);
        xfer(0, 1'b0, 8'h00, 64'h10, 64'd0, n);
        idle(2);
        chk("t2_rdata_be0f", rdata[0], 64'h11223344AAAAAAAA);
        xfer(0, 1'b1, 8'h00, 64'h10, 64'hFFFFFFFFFFFFFFFF, n);
        xfer(0, 1'b0, 8'hFF, 64'h10, 64'd0, n);
        idle(2);
        chk("t2_rdata_be00", rdata[0], 64'h11223344AAAAAAAA);

        // Aliasing: 0x2000 is word 0 again in a 1024-word memory.
        xfer(0, 1'b1, 8'hFF, 64'h2000, 64'hDEADBEEF00000001, n);
        xfer(0, 1'b0, 8'h00, 64'h0, 64'd0, n);
        idle(2);
        chk("t6_alias", rdata[0], 64'hDEADBEEF00000001);

        // Wait states: each held request waits two cycles, grant on the third.
        xfer(1, 1'b0, 8'h00, 64'h08, 64'd0, n);
        chk("t3_first_wait", 64'(n), 64'd3);
        xfer(1, 1'b0, 8'h00, 64'h08, 64'd0, n);
        chk("t3_second_wait", 64'(n), 64'd3);
        idle(6);
        saved = mref[1][3];
        req[1] = 1'b1; we[1] = 1'b1; be[1] = 8'hFF; addr[1] = 64'h18; wdata[1] = ~saved;
        idle(2);
        req[1] = 1'b0;                      // dropped before its grant
        idle(1);
        xfer(1, 1'b0, 8'h00, 64'h18, 64'd0, n);
        chk("t3_after_drop_wait", 64'(n), 64'd3);
        idle(5);
        chk("t3_drop_no_write", rdata[1], saved);

        // Back-to-back reads with three-cycle latency.
        xfer(2, 1'b1, 8'hFF, 64'h00, 64'h0A0A0A0A0A0A0A0A, n);
        xfer(2, 1'b1, 8'hFF, 64'h08, 64'h0B0B0B0B0B0B0B0B, n);
        xfer(2, 1'b1, 8'hFF, 64'h10, 64'h0C0C0C0C0C0C0C0C, n);
        idle(4);
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 64'h00;
        step();
        addr[2] = 64'h08;
        step();
        addr[2] = 64'h10;
        step();
        req[2] = 1'b0;
        cnt = 0; first = -1;
        for (int k = 0; k < 6; k++) begin
            if (rvalid[2]) begin
                if (cnt < 3) got[cnt] = rdata[2];
                if (first < 0) first = k;
                cnt++;
            end
            step();
        end
        chk("t4_count", 64'(cnt), 64'd3);
        chk("t4_first_cycle", 64'(first), 64'd0);
        chk("t4_data0", got[0], 64'h0A0A0A0A0A0A0A0A);
        chk("t4_data1", got[1], 64'h0B0B0B0B0B0B0B0B);
        chk("t4_data2", got[2], 64'h0C0C0C0C0C0C0C0C);

        // Reset one cycle after a read is accepted discards it.
        xfer(2, 1'b0, 8'h00, 64'h08, 64'd0, n);
        rst = 1'b1;
        req[2] = 1'b1;
        step();
        req[2] = 1'b0;
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (rvalid[2]) cnt++;
        end
        chk("t5_no_rvalid", 64'(cnt), 64'd0);
        chk("t5_rdata_cleared", rdata[2], 64'd0);

        // Random traffic: back-to-back requests, host drops, partial writes, resets.
        for (int it = 0; it < 2000; it++) begin
            for (int d = 0; d < ND; d++) begin
                if (!req[d]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        req[d]   = 1'b1;
                        we[d]    = 1'($urandom_range(0, 1));
                        be[d]    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                        addr[d]  = {$urandom, $urandom};
                        addr[d][12:3] = 10'($urandom_range(0, 15));
                        wdata[d] = {$urandom, $urandom};
                    end
                end else if ($urandom_range(0, 99) == 0) begin
                    req[d] = 1'b0;
                end
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
            for (int d = 0; d < ND; d++)
                if (acc[d]) req[d] = 1'b0;
        end
        rst = 1'b0;
        for (int d = 0; d < ND; d++) req[d] = 1'b0;
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
